// File: rtl/instr_fetch.sv
// instr_fetch: two-state (REQ/VALID) instruction fetch unit with jump/branch next-PC selection.
// Optional consumed-instruction counter on port fetch_cnt when IFETCH_PERF_CNT_EN is defined.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        jump,
    input  logic        branch_taken,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [31:0] pc_out
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);
    typedef enum logic {S_REQ, S_VALID} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4, br_off, next_pc;
    logic        consume;

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        next_pc  = jump ? {pc_plus4[31:28], instr_q[25:0], 2'b00} :
                   branch_taken ? pc_plus4 + br_off : pc_plus4;
        consume  = (state_q == S_VALID) && !stall;
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        // imem_ready is only honoured while requesting; in VALID the held word is frozen
        if (state_q == S_REQ && imem_ready) begin
            instr_d = imem_rdata;
            state_d = S_VALID;
        end
        if (consume) begin
            pc_d    = next_pc;
            state_d = S_REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_VALID);
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign func        = instr_q[5:0];
    assign pc_out      = pc_q;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb cnt_d = consume ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 32'h0;
        else        cnt_q <= cnt_d;
    end

    assign fetch_cnt = cnt_q;
`endif
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first instruction address after reset (bits [1:0] SHALL be 00).
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-005 SHALL have port imem_addr, output, 32 bits: word-aligned fetch address.
REQ-006 SHALL have port imem_ready, input, 1 bit: memory returns imem_rdata this cycle.
REQ-007 SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-008 SHALL have port stall, input, 1 bit: downstream not accepting the presented instruction.
REQ-009 SHALL have port jump, input, 1 bit: the presented instruction is J-type jump (from control decode).
REQ-010 SHALL have port branch_taken, input, 1 bit: Branch AND ALU zero for the presented instruction.
REQ-011 SHALL have port instr_valid, output, 1 bit: instr/op/func/pc_out are valid.
REQ-012 SHALL have port instr, output, 32 bits: held instruction register.
REQ-013 SHALL have ports op and func, output, 6 bits each: instr[31:26] and instr[5:0], fed to the control unit.
REQ-014 SHALL have port pc_out, output, 32 bits: address of the held instruction.
REQ-015 SHALL have port fetch_cnt, output, 32 bits: consumed-instruction count (present only per REQ-030).

Function
REQ-016 SHALL implement FSM states REQ and VALID; no other reachable state.
REQ-017 In REQ: imem_req=1, imem_addr=pc, instr_valid=0; on edge with imem_ready=1, capture imem_rdata into instr and go to VALID; else stay in REQ with address held stable.
REQ-018 In VALID: imem_req=0, instr_valid=1, instr/pc_out stable; consume occurs on an edge with stall=0.
REQ-019 On consume: pc <= next_pc, state <= REQ; with stall=1, state and all outputs hold indefinitely.
REQ-020 next_pc SHALL be: jump=1 -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch_taken=1 -> pc_plus4 + (sign_extend(instr[15:0]) << 2); else pc_plus4; pc_plus4 = pc + 4, modulo 2^32.
REQ-021 jump SHALL take priority over branch_taken when both are 1.
REQ-022 jump and branch_taken SHALL be sampled only on the consume edge; ignored in REQ or while stall=1.
REQ-023 imem_ready while in VALID SHALL be ignored; imem_rdata SHALL not alter instr there.
REQ-024 Minimum latency: request cycle to instr_valid=1 is one cycle (ready in first REQ cycle); steady throughput is one instruction per two cycles.
REQ-025 PC wrap: pc 32'hFFFF_FFFC sequential next_pc SHALL be 32'h0000_0000.
REQ-026 op and func SHALL be purely combinational slices of instr, no extra latency.

Reset
REQ-027 rst_n=0 SHALL immediately (asynchronously) force state=REQ, pc=RESET_PC, instr=0, instr_valid=0, fetch_cnt=0; imem_req is 1 once rst_n deasserts.
REQ-028 Reset mid-request SHALL abandon the outstanding fetch; a late imem_ready after reset applies to address RESET_PC only.
REQ-029 Deassertion SHALL be synchronized externally; first request issues in the first cycle after deassertion.

Configuration
REQ-030 Macro IFETCH_PERF_CNT_EN: defined -> fetch_cnt port exists, increments by 1 on every consume edge, wraps 32'hFFFF_FFFF -> 0, cleared by reset; undefined -> fetch_cnt port and its register SHALL be absent, all other behaviour identical.

Verification
REQ-031 Reset release, imem_ready=1 always, stall=0, no branch/jump -> imem_addr sequence 0,4,8,12; instr_valid pulses every second cycle.
REQ-032 In VALID at pc=0x40, instr=0x1000_0003, branch_taken=1, stall=0 -> next imem_addr=0x50.
REQ-033 In VALID at pc=0x1000_0040, instr=0x0800_0010, jump=1 and branch_taken=1 -> next imem_addr=0x1000_0040 (jump wins); branch offset 0xFFFF at pc=0x40 -> 0x40.
REQ-034 stall=1 held 5 cycles in VALID with jump toggling -> instr, pc_out, instr_valid unchanged, imem_req=0; on release, next_pc from jump value at release edge only.
REQ-035 imem_ready delayed 3 cycles, then rst_n pulsed low mid-VALID -> instr_valid drops immediately, imem_addr=RESET_PC, fetch_cnt=0 (with IFETCH_PERF_CNT_EN; counts 3 after three consumes).
